inst_fetch_unit: RTL and testbench

//  Instruction-side producer for the MIPS controller. Holds the PC, fetches words from instruction memory

---
 rtl/mips_pkg.sv | 16 +
 rtl/pc_next_logic.sv | 31 +++
 rtl/inst_fetch_unit.sv | 87 ++++++++
 tb/tb_inst_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS controller: opcode constants, the
// instruction width and the fetch-unit FSM state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the consume cycle: jump beats a taken branch, and a
// taken branch beats sequential flow. Only instr[25:0] is needed here, because
// the jump index and the branch immediate both live in those bits.
import mips_pkg::*;

module pc_next_logic (
    input  logic [INSTR_W-1:0] pc_plus4,
    input  logic [25:0]        instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [INSTR_W-1:0] next_pc
);

    logic [INSTR_W-1:0] jump_target;
    logic [INSTR_W-1:0] branch_offset;

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Priority select; every candidate keeps bits [1:0] at zero.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words over a req/ack
// handshake and presents them to the decoder over a valid/ready handshake.
import mips_pkg::*;

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic [CNT_W-1:0]   retire_cnt
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] next_pc;

    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    pc_next_logic u_pc_next (
        .pc_plus4 (pc_plus4),
        .instr    (instr[25:0]),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // Fetch/issue FSM; req and valid are registered alongside the state so
    // they only change on state transitions, and ack is ignored outside fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RST;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            case (state)
                S_RST: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        retire_cnt  <= retire_cnt + CNT_W'(1);
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state       <= S_RST;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit. Three instances cover a zero reset
// PC, the wrap-around reset PC and a high reset PC for the jump region test.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0020;
    localparam logic [31:0] BEQ_NEG = 32'h1000_FFFE;
    localparam logic [31:0] J_40    = 32'h0800_0040;
    localparam logic [31:0] J_80    = 32'h0800_0080;

    int tests_run;
    int tests_failed;

    logic clk;
    logic rst;
    logic imem_ack;
    logic [31:0] imem_rdata;
    logic instr_ready;
    logic branch;
    logic jump;
    logic zero;

    logic imem_req;
    logic [31:0] imem_addr;
    logic instr_valid;
    logic [31:0] instr;
    logic [5:0] op;
    logic [5:0] funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;

    logic rst_b;
    logic ack_b;
    logic [31:0] rdata_b;
    logic ready_b;
    logic branch_j;
    logic jump_j;
    logic zero_j;

    logic w_req;
    logic [31:0] w_addr;
    logic w_valid;
    logic [31:0] w_instr;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_cnt;

    logic j_req;
    logic [31:0] j_addr;
    logic j_valid;
    logic [31:0] j_instr;
    logic [5:0] j_op;
    logic [5:0] j_funct;
    logic [31:0] j_pc;
    logic [31:0] j_pc_plus4;
    logic [31:0] j_cnt;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .jump(jump), .zero(zero),
        .instr(instr), .op(op), .funct(funct),
        .pc(pc), .pc_plus4(pc_plus4), .retire_cnt(retire_cnt)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
        .clk(clk), .rst(rst_b),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(ack_b), .imem_rdata(rdata_b),
        .instr_valid(w_valid), .instr_ready(ready_b),
        .branch(1'b0), .jump(1'b0), .zero(1'b0),
        .instr(w_instr), .op(w_op), .funct(w_funct),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .retire_cnt(w_cnt)
    );

    inst_fetch_unit #(.RESET_PC(32'h4000_0010), .CNT_W(32)) dut_jump (
        .clk(clk), .rst(rst_b),
        .imem_req(j_req), .imem_addr(j_addr),
        .imem_ack(ack_b), .imem_rdata(rdata_b),
        .instr_valid(j_valid), .instr_ready(ready_b),
        .branch(branch_j), .jump(jump_j), .zero(zero_j),
        .instr(j_instr), .op(j_op), .funct(j_funct),
        .pc(j_pc), .pc_plus4(j_pc_plus4), .retire_cnt(j_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word with an immediate ack, then consume it with the given
    // decoder flags; leaves the main instance back in fetch at its next PC.
    task automatic applyStimulus(input logic [31:0] word, input logic br, input logic jp, input logic zr);
        imem_ack = 1'b1;
        imem_rdata = word;
        stepCycle();
        imem_ack = 1'b0;
        branch = br;
        jump = jp;
        zero = zr;
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        zero = 1'b0;
    endtask

    // Directed sequence covering reset, handshakes, branches, jumps and wrap.
    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        rst_b = 1'b0; ack_b = 1'b0; rdata_b = '0; ready_b = 1'b0;
        branch_j = 1'b0; jump_j = 1'b0; zero_j = 1'b0;

        repeat (2) stepCycle();
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_cnt", retire_cnt, 32'd0);

        // Reset release with ack already waiting.
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = NOP;
        stepCycle();
        checkOutput("c1_req", 32'(imem_req), 32'd1);
        checkOutput("c1_addr", imem_addr, 32'h0);
        checkOutput("c1_valid", 32'(instr_valid), 32'd0);
        stepCycle();
        checkOutput("c2_valid", 32'(instr_valid), 32'd1);
        checkOutput("c2_instr", instr, NOP);
        checkOutput("c2_funct", 32'(funct), 32'h20);
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0);
        checkOutput("seq_cnt", retire_cnt, 32'd4);
        checkOutput("seq_pc", pc, 32'h10);

        // Memory wait states.
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_addr", imem_addr, 32'h10);
            checkOutput("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0123_4567;
        stepCycle();
        imem_ack = 1'b0;
        checkOutput("wait_done_valid", 32'(instr_valid), 32'd1);

        // Spurious ack while req is low.
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        stepCycle();
        imem_ack = 1'b0;
        checkOutput("spur_instr", instr, 32'h0123_4567);
        checkOutput("spur_req", 32'(imem_req), 32'd0);

        // Decoder backpressure.
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("bp_instr", instr, 32'h0123_4567);
            checkOutput("bp_pc", pc, 32'h10);
            checkOutput("bp_valid", 32'(instr_valid), 32'd1);
            checkOutput("bp_req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        checkOutput("bp_cnt", retire_cnt, 32'd5);
        checkOutput("bp_pc_after", pc, 32'h14);

        // Branches at 0x20.
        for (int i = 0; i < 3; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_br_pc", pc, 32'h20);
        applyStimulus(BEQ_NEG, 1'b1, 1'b0, 1'b1);
        checkOutput("br_taken_addr", imem_addr, 32'h1C);
        applyStimulus(NOP, 1'b0, 1'b0, 1'b0);
        applyStimulus(BEQ_NEG, 1'b1, 1'b0, 1'b0);
        checkOutput("br_not_taken", imem_addr, 32'h24);
        checkOutput("br_cnt", retire_cnt, 32'd11);

        // Jump and wrap instances.
        rst_b = 1'b1;
        stepCycle();
        checkOutput("j_addr0", j_addr, 32'h4000_0010);
        checkOutput("w_addr0", w_addr, 32'hFFFF_FFFC);
        ack_b = 1'b1;
        rdata_b = J_40;
        stepCycle();
        ack_b = 1'b0;
        checkOutput("j_op", 32'(j_op), 32'h02);
        checkOutput("w_pc_plus4", w_pc_plus4, 32'h0);
        jump_j = 1'b1;
        ready_b = 1'b1;
        stepCycle();
        ready_b = 1'b0;
        jump_j = 1'b0;
        checkOutput("j_target", j_addr, 32'h4000_0100);
        checkOutput("w_wrap", w_addr, 32'h0);
        ack_b = 1'b1;
        rdata_b = J_80;
        stepCycle();
        ack_b = 1'b0;
        jump_j = 1'b1;
        branch_j = 1'b1;
        zero_j = 1'b1;
        ready_b = 1'b1;
        stepCycle();
        ready_b = 1'b0;
        jump_j = 1'b0;
        branch_j = 1'b0;
        zero_j = 1'b0;
        checkOutput("j_over_br", j_addr, 32'h4000_0200);
        checkOutput("j_cnt", j_cnt, 32'd2);

        // Reset during fetch with an ack in the same cycle.
        checkOutput("w_req_pre", 32'(w_req), 32'd1);
        rst_b = 1'b0;
        ack_b = 1'b1;
        rdata_b = 32'hDEAD_BEEF;
        stepCycle();
        checkOutput("rf_instr", w_instr, 32'h0);
        checkOutput("rf_pc", w_pc, 32'hFFFF_FFFC);
        checkOutput("rf_valid", 32'(w_valid), 32'd0);
        checkOutput("rf_j_pc", j_pc, 32'h4000_0010);
        rst_b = 1'b1;
        stepCycle();
        ack_b = 1'b0;
        checkOutput("rf_after_instr", w_instr, 32'h0);
        checkOutput("rf_after_valid", 32'(w_valid), 32'd0);
        checkOutput("rf_after_req", 32'(w_req), 32'd1);
        checkOutput("rf_after_cnt", w_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
